imul_int_mul_param: RTL
=======================

Name: imul_int_mul_param

Overview:
- Parametrised successor to the fixed-latency iterative shift-add integer multiplier.
- Width is generic, and each transaction selects signed or unsigned mode.
- Returns the full 2N-bit product.
- Optional early termination makes latency depend on the operand (variable latency).
- Sits on the lab1_imul val/rdy stream interface. It is a drop-in behind the same source and sink test harness, with widened messages.

Parameters:
- p_nbits, 32: operand width N; must be >= 2.
- p_early_exit, 1: 1 = leave CALC as soon as the remaining multiplier bits are all zero; 0 = always N CALC cycles.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- istream_val  input  1  request valid.
- istream_rdy  output  1  request ready.
- istream_msg  input  2N+1  {signed_mode[2N], a[2N-1:N], b[N-1:0]}.
- ostream_val  output  1  response valid.
- ostream_rdy  input  1  response ready.
- ostream_msg  output  2N  full product a*b: two's complement if signed_mode, else unsigned.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, counter=0, result register=0, negate flag=0.
  - Outputs after reset: istream_rdy=1, ostream_val=0, ostream_msg=0.
  - Reset asserted in any state, mid-CALC included, abandons the operation. No response is produced for it.
- States: IDLE, CALC, DONE, as a 2-bit encoding. Unused encodings behave as IDLE.
- IDLE:
  - istream_rdy=1, ostream_val=0.
  - On istream_val&&istream_rdy the block loads its registers and goes to CALC:
    - a_reg (2N bits) = zero-extended |a|.
    - b_reg (N bits) = |b|.
    - result = 0, counter = 0.
    - neg = signed_mode && (a[N-1] ^ b[N-1]).
  - |x| = x when unsigned, or when signed and non-negative; otherwise the two's-complement negation, taken as an N-bit unsigned value. The most negative value -2^(N-1) maps to 2^(N-1) with no overflow.
- CALC:
  - istream_rdy=0, ostream_val=0.
  - Each cycle:
    - if b_reg[0]=1, result += a_reg (2N-bit add, no overflow possible);
    - a_reg <<= 1;
    - b_reg >>= 1 (logical);
    - counter++.
  - Goes to DONE when counter==N-1, or when p_early_exit=1 and (b_reg>>1)==0.
- DONE:
  - ostream_val=1, istream_rdy=0.
  - ostream_msg = neg ? -result : result, negated over 2N bits.
  - On ostream_rdy, goes to IDLE. Otherwise holds, with ostream_msg stable.
- Latency, accept to ostream_val:
  - p_early_exit=0: N+1 cycles.
  - p_early_exit=1: C+1 cycles, where C = max(1, msb_index(|b|)+1). |b|=0 and |b|=1 each give C=1.
- Throughput: a new request is accepted no earlier than the cycle after the DONE handshake. There is no overlap of DONE and IDLE.
- Counter width: $clog2(p_nbits)+1. It does not wrap within a transaction.
- istream_msg is sampled only on the accept cycle. Later changes to the input have no effect on the transaction in flight.
- Line trace:
  - input val/rdy message, then "(" state mnemonic I/C/D and counter ")", then output val/rdy message.

Decomposition:
- Package imul_int_mul_param_pkg holds:
  - state typedef enum logic [1:0] {IDLE, CALC, DONE};
  - localparam field-offset helpers for msg packing.
- Sub-modules:
  - imul_int_mul_param_dpath: abs units, a/b/result registers, shifters, adder, output negate. It uses vc_ muxes, regs and arithmetic.
  - imul_int_mul_param_ctrl: FSM, vc_BasicCounter and the early-exit compare.
  - The top level only wires these two together.
- Control signals: a/b load selects, result_en, result_clear, add_en, neg_en, counter clear/increment. The datapath returns b_reg and b_next_is_zero as status.

Test Plan:
- Unsigned, N=32, early exit on: a=3, b=5 -> product 0x0000_0000_0000_000F; ostream_val rises 4 cycles after accept (C=3).
- Signed: a=0xFFFF_FFFD (-3), b=7 -> 0xFFFF_FFFF_FFFF_FFEB (-21). Also -2^31 * -2^31 -> 0x4000_0000_0000_0000.
- Unsigned max and zero:
  - 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFE_0000_0001 after 33 cycles.
  - b=0 -> 0 after 2 cycles.
  - Repeat with p_early_exit=0: every transaction takes exactly 33 cycles.
- Backpressure: hold ostream_rdy=0 for 10 cycles in DONE -> ostream_val and ostream_msg stable, istream_rdy=0. Then ostream_rdy=1 -> IDLE next cycle, and a back-to-back request is accepted.
- Reset mid-CALC: assert reset on cycle 5 of a 32-cycle op -> next cycle istream_rdy=1 and ostream_val=0. The following request 6*7 returns 42 with no stale response.
- Parametric: N=8, signed, a=0x80, b=0x80 -> 0x4000. Random signed/unsigned N=8 sweep against a golden model with random val/rdy delays.

Source files
------------

// File: rtl/imul_int_mul_param_pkg.sv
// Shared types and message-field helpers for the parametrised
// iterative shift-add multiplier.
package imul_int_mul_param_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DefNbits = 32;

  // Request message is {signed_mode, a, b}
  function automatic int msg_b_lsb(input int n);
    return 0;
  endfunction

  function automatic int msg_a_lsb(input int n);
    return n;
  endfunction

  function automatic int msg_sgn_bit(input int n);
    return 2 * n;
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/imul_int_mul_param_ctrl.sv
// Control FSM: handshakes, iteration counter and
// early-exit decision.
module imul_int_mul_param_ctrl
  import imul_int_mul_param_pkg::*;
#(
  parameter int P_NBITS      = 32,
  parameter int P_EARLY_EXIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic istream_val_i,
  output logic istream_rdy_o,
  output logic ostream_val_o,
  input  logic ostream_rdy_i,
  input  logic b_lsb_i,
  input  logic b_next_is_zero_i,
  output logic a_load_o,
  output logic b_load_o,
  output logic shift_en_o,
  output logic result_en_o,
  output logic result_clear_o,
  output logic add_en_o,
  output logic neg_en_o
);

  localparam int CW = cnt_width(P_NBITS);
  localparam logic [CW-1:0] CntLast = CW'(P_NBITS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_clr, cnt_inc;
  logic          load, calc, last;

  assign last = (cnt_q == CntLast) ||
                ((P_EARLY_EXIT != 0) && b_next_is_zero_i);

  always_comb begin
    state_d       = state_q;
    istream_rdy_o = 1'b0;
    ostream_val_o = 1'b0;
    load          = 1'b0;
    calc          = 1'b0;
    case (state_q)
      CALC: begin
        calc = 1'b1;
        if (last)
          state_d = DONE;
      end
      DONE: begin
        ostream_val_o = 1'b1;
        if (ostream_rdy_i)
          state_d = IDLE;
      end
      // IDLE and the unused encoding
      default: begin
        istream_rdy_o = 1'b1;
        state_d       = IDLE;
        if (istream_val_i) begin
          load    = 1'b1;
          state_d = CALC;
        end
      end
    endcase
  end

  assign cnt_clr = load;
  assign cnt_inc = calc;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (cnt_inc)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign a_load_o       = load;
  assign b_load_o       = load;
  assign result_clear_o = load;
  assign neg_en_o       = load;
  assign shift_en_o     = calc;
  assign result_en_o    = calc;
  assign add_en_o       = b_lsb_i;

endmodule

// File: rtl/imul_int_mul_param_dpath.sv
// Datapath: operand magnitude units, shift registers,
// accumulator and final sign correction.
module imul_int_mul_param_dpath
  import imul_int_mul_param_pkg::*;
#(
  parameter int P_NBITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*P_NBITS:0]   msg_i,
  input  logic                 a_load_i,
  input  logic                 b_load_i,
  input  logic                 shift_en_i,
  input  logic                 result_en_i,
  input  logic                 result_clear_i,
  input  logic                 add_en_i,
  input  logic                 neg_en_i,
  output logic                 b_lsb_o,
  output logic                 b_next_is_zero_o,
  output logic [2*P_NBITS-1:0] prod_o
);

  localparam int N    = P_NBITS;
  localparam int SgnB = msg_sgn_bit(N);
  localparam int ALsb = msg_a_lsb(N);
  localparam int BLsb = msg_b_lsb(N);

  logic         sgn;
  logic [N-1:0] a_in;
  logic [N-1:0] b_in;
  logic [N-1:0] a_abs;
  logic [N-1:0] b_abs;

  assign sgn  = msg_i[SgnB];
  assign a_in = msg_i[ALsb +: N];
  assign b_in = msg_i[BLsb +: N];

  // -2^(N-1) negates to itself, read back as unsigned 2^(N-1)
  assign a_abs = (sgn && a_in[N-1]) ? -a_in : a_in;
  assign b_abs = (sgn && b_in[N-1]) ? -b_in : b_in;

  logic [2*N-1:0] a_q, a_d;
  logic [2*N-1:0] res_q, res_d;
  logic [N-1:0]   b_q, b_d;
  logic           neg_q, neg_d;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    res_d = res_q;
    neg_d = neg_q;
    if (a_load_i)
      a_d = {{N{1'b0}}, a_abs};
    else if (shift_en_i)
      a_d = a_q << 1;
    if (b_load_i)
      b_d = b_abs;
    else if (shift_en_i)
      b_d = b_q >> 1;
    if (result_clear_i)
      res_d = '0;
    else if (result_en_i && add_en_i)
      res_d = res_q + a_q;
    if (neg_en_i)
      neg_d = sgn & (a_in[N-1] ^ b_in[N-1]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      neg_q <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      res_q <= res_d;
      neg_q <= neg_d;
    end
  end

  assign b_lsb_o          = b_q[0];
  assign b_next_is_zero_o = (b_q[N-1:1] == '0);
  assign prod_o           = neg_q ? -res_q : res_q;

endmodule

// File: rtl/imul_int_mul_param.sv
// Parametrised signed/unsigned iterative multiplier on a
// val/rdy stream; top level wires control to datapath.
module imul_int_mul_param
  import imul_int_mul_param_pkg::*;
#(
  parameter int p_nbits      = 32,
  parameter int p_early_exit = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 istream_val,
  output logic                 istream_rdy,
  input  logic [2*p_nbits:0]   istream_msg,
  output logic                 ostream_val,
  input  logic                 ostream_rdy,
  output logic [2*p_nbits-1:0] ostream_msg
);

  logic a_load, b_load, shift_en;
  logic result_en, result_clear, add_en, neg_en;
  logic b_lsb, b_next_is_zero;

  imul_int_mul_param_ctrl #(
    .P_NBITS      (p_nbits),
    .P_EARLY_EXIT (p_early_exit)
  ) u_ctrl (
    .clk              (clk),
    .reset            (reset),
    .istream_val_i    (istream_val),
    .istream_rdy_o    (istream_rdy),
    .ostream_val_o    (ostream_val),
    .ostream_rdy_i    (ostream_rdy),
    .b_lsb_i          (b_lsb),
    .b_next_is_zero_i (b_next_is_zero),
    .a_load_o         (a_load),
    .b_load_o         (b_load),
    .shift_en_o       (shift_en),
    .result_en_o      (result_en),
    .result_clear_o   (result_clear),
    .add_en_o         (add_en),
    .neg_en_o         (neg_en)
  );

  imul_int_mul_param_dpath #(
    .P_NBITS (p_nbits)
  ) u_dpath (
    .clk              (clk),
    .reset            (reset),
    .msg_i            (istream_msg),
    .a_load_i         (a_load),
    .b_load_i         (b_load),
    .shift_en_i       (shift_en),
    .result_en_i      (result_en),
    .result_clear_i   (result_clear),
    .add_en_i         (add_en),
    .neg_en_i         (neg_en),
    .b_lsb_o          (b_lsb),
    .b_next_is_zero_o (b_next_is_zero),
    .prod_o           (ostream_msg)
  );

endmodule
